// File: rtl/path_pkg.sv
// ============================================================================
//  Module : path_pkg
//  Brief  : Shared types, state encoding and saturating add for the path engine.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package path_pkg;

    localparam int NODE_W_DEF = 5;
    localparam int DIST_W_DEF = 8;
    localparam logic [DIST_W_DEF-1:0] c_INF = '1;

    typedef logic [NODE_W_DEF-1:0] node_id_t;
    typedef logic [DIST_W_DEF-1:0] dist_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SCAN  = 3'd2,
        S_FETCH = 3'd3,
        S_LOAD  = 3'd4,
        S_RELAX = 3'd5,
        S_DONE  = 3'd6,
        S_TRACE = 3'd7
    } state_t;

    // All-ones of a dw-bit cost is reserved for "unreached", so sums clamp one below it.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] w,
                                            input int unsigned dw);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, w};
        lim = (33'd1 << dw) - 33'd1;
        if (s >= lim) s = lim - 33'd1;
        return s[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/path_min_scan.sv
// ============================================================================
//  Module : path_min_scan
//  Brief  : Sequential argmin over unvisited, reachable nodes; lowest id wins ties.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module path_min_scan #(
    parameter int NODE_W = 5,
    parameter int DIST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_i,
    input  logic              first_i,
    input  logic [NODE_W-1:0] idx_i,
    input  logic [DIST_W-1:0] dist_i,
    input  logic              visited_i,
    output logic [NODE_W-1:0] min_id_o,
    output logic [DIST_W-1:0] min_dist_o,
    output logic              any_valid_o
);

    localparam logic [DIST_W-1:0] c_INF = '1;

    logic [NODE_W-1:0] id_q;
    logic [DIST_W-1:0] md_q;
    logic              valid_q;
    logic              w_base_valid;
    logic [DIST_W-1:0] w_base_dist;
    logic              w_take;

    // Outputs already fold in the element presented this cycle, so the
    // result is usable in the same cycle as the last step.
    always_comb begin
        w_base_valid = valid_q & ~first_i;
        w_base_dist  = w_base_valid ? md_q : c_INF;
        w_take       = step_i && !visited_i && (dist_i != c_INF) && (dist_i < w_base_dist);
        min_id_o     = w_take ? idx_i  : id_q;
        min_dist_o   = w_take ? dist_i : w_base_dist;
        any_valid_o  = w_take | w_base_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            md_q    <= c_INF;
            valid_q <= 1'b0;
        end else if (step_i) begin
            id_q    <= min_id_o;
            md_q    <= min_dist_o;
            valid_q <= any_valid_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/path_search_engine.sv
// ============================================================================
//  Module : path_search_engine
//  Brief  : Dijkstra shortest-path engine with linear min-scan and external
//           adjacency table. Optional path streaming under PATH_TRACE_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module path_search_engine
    import path_pkg::*;
#(
    parameter int N_NODES = 26,
    parameter int NODE_W  = 5,
    parameter int DEG     = 4,
    parameter int WGT_W   = 2,
    parameter int DIST_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NODE_W-1:0]     st_node,
    input  logic [NODE_W-1:0]     end_node,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [DIST_W-1:0]     path_cost,
    output logic                  adj_rd_en,
    output logic [NODE_W-1:0]     adj_addr,
    input  logic [DEG*NODE_W-1:0] adj_node,
    input  logic [DEG*WGT_W-1:0]  adj_wgt,
    input  logic [NODE_W-1:0]     q_addr,
    output logic [NODE_W-1:0]     q_prev,
    output logic [DIST_W-1:0]     q_dist
`ifdef PATH_TRACE_EN
    ,
    output logic [NODE_W-1:0]     trace_node,
    output logic                  trace_valid,
    output logic                  trace_last,
    input  logic                  trace_ready
`endif
);

    localparam int                c_SLOT_W = (DEG > 1) ? $clog2(DEG) : 1;
    localparam logic [DIST_W-1:0] c_DIST_INF = '1;
    localparam logic [NODE_W:0]   c_N = (NODE_W+1)'(N_NODES);
    localparam logic [NODE_W-1:0] c_LAST = NODE_W'(N_NODES-1);

    state_t              state_q, state_d;
    logic [NODE_W-1:0]   st_q, end_q, cur_q, cnt_q;
    logic [c_SLOT_W-1:0] slot_q;
    logic                found_q;
    logic [DIST_W-1:0]   path_cost_q;
    logic [DIST_W-1:0]   dist_q    [N_NODES];
    logic [NODE_W-1:0]   prev_q    [N_NODES];
    logic [N_NODES-1:0]  visited_q;
    logic [NODE_W-1:0]   enode_q   [DEG];
    logic [WGT_W-1:0]    ewgt_q    [DEG];
`ifdef PATH_TRACE_EN
    logic [NODE_W-1:0]   tr_q;
`endif

    logic                w_start_ok, w_cnt_last, w_slot_last;
    logic [NODE_W-1:0]   w_min_id;
    logic [DIST_W-1:0]   w_min_dist;
    logic                w_any_valid;
    logic [NODE_W-1:0]   w_nn, w_nn_idx;
    logic                w_nn_ok;
    logic [DIST_W-1:0]   w_nd;
    logic                w_relax;

    path_min_scan #(
        .NODE_W (NODE_W),
        .DIST_W (DIST_W)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .step_i      (state_q == S_SCAN),
        .first_i     (cnt_q == '0),
        .idx_i       (cnt_q),
        .dist_i      (dist_q[cnt_q]),
        .visited_i   (visited_q[cnt_q]),
        .min_id_o    (w_min_id),
        .min_dist_o  (w_min_dist),
        .any_valid_o (w_any_valid)
    );

    always_comb begin
        w_start_ok  = ({1'b0, st_node} < c_N) && ({1'b0, end_node} < c_N);
        w_cnt_last  = (cnt_q == c_LAST);
        w_slot_last = (slot_q == c_SLOT_W'(DEG-1));
        w_nn        = enode_q[slot_q];
        w_nn_idx    = ({1'b0, w_nn} < c_N) ? w_nn : '0;
        w_nn_ok     = ({1'b0, w_nn} < c_N) && !visited_q[w_nn_idx];
        w_nd        = DIST_W'(sat_add(32'(dist_q[cur_q]), 32'(ewgt_q[slot_q]), DIST_W));
        w_relax     = w_nn_ok && (w_nd < dist_q[w_nn_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        adj_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = w_start_ok ? S_INIT : S_DONE;
            end
            S_INIT:  if (w_cnt_last) state_d = S_SCAN;
            S_SCAN: begin
                if (w_cnt_last) begin
                    if (!w_any_valid)         state_d = S_DONE;
`ifdef PATH_TRACE_EN
                    else if (w_min_id == end_q) state_d = S_TRACE;
`else
                    else if (w_min_id == end_q) state_d = S_DONE;
`endif
                    else                      state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                adj_rd_en = 1'b1;
                state_d   = S_LOAD;
            end
            S_LOAD:  state_d = S_RELAX;
            S_RELAX: if (w_slot_last) state_d = S_SCAN;
`ifdef PATH_TRACE_EN
            S_TRACE: if (trace_ready && (tr_q == st_q)) state_d = S_DONE;
`endif
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= '0;
            end_q       <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            found_q     <= 1'b0;
            path_cost_q <= c_DIST_INF;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        st_q    <= st_node;
                        end_q   <= end_node;
                        found_q <= 1'b0;
                        cnt_q   <= '0;
                        if (!w_start_ok) path_cost_q <= c_DIST_INF;
                    end
                end
                S_INIT: begin
                    dist_q[cnt_q]    <= c_DIST_INF;
                    prev_q[cnt_q]    <= cnt_q;
                    visited_q[cnt_q] <= 1'b0;
                    cnt_q            <= cnt_q + 1'b1;
                    if (w_cnt_last) begin
                        dist_q[st_q] <= '0;
                        cnt_q        <= '0;
                    end
                end
                S_SCAN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (w_cnt_last) begin
                        cnt_q <= '0;
                        if (w_any_valid) begin
                            cur_q               <= w_min_id;
                            visited_q[w_min_id] <= 1'b1;
                            if (w_min_id == end_q) begin
                                found_q     <= 1'b1;
                                path_cost_q <= w_min_dist;
                            end
                        end else begin
                            path_cost_q <= c_DIST_INF;
                        end
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < DEG; i++) begin
                        enode_q[i] <= adj_node[i*NODE_W +: NODE_W];
                        ewgt_q[i]  <= adj_wgt[i*WGT_W +: WGT_W];
                    end
                    slot_q <= '0;
                end
                S_RELAX: begin
                    // Strict less-than: the earliest relaxation of equal cost is kept.
                    if (w_relax) begin
                        dist_q[w_nn_idx] <= w_nd;
                        prev_q[w_nn_idx] <= cur_q;
                    end
                    slot_q <= slot_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PATH_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tr_q <= '0;
        end else if (state_q == S_SCAN && w_cnt_last) begin
            tr_q <= end_q;
        end else if (state_q == S_TRACE && trace_ready && (tr_q != st_q)) begin
            tr_q <= prev_q[tr_q];
        end
    end

    always_comb begin
        trace_node  = tr_q;
        trace_valid = (state_q == S_TRACE);
        trace_last  = (state_q == S_TRACE) && (tr_q == st_q);
    end
`endif

    always_comb begin
        found     = found_q;
        path_cost = path_cost_q;
        adj_addr  = cur_q;
        q_prev    = ({1'b0, q_addr} < c_N) ? prev_q[q_addr] : q_addr;
        q_dist    = ({1'b0, q_addr} < c_N) ? dist_q[q_addr] : c_DIST_INF;
    end

endmodule

`default_nettype wire
